alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational 4-bit ALU: latches a command, holds the
// operands for SETTLE_CYCLES, captures the ALU outputs and returns them over a response handshake.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_opp,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       accept, legal, capture, rsp_hs, logic_op;

    // cmd_ready is gated by rst_n so it stays low while reset is held
    assign cmd_ready = (state == IDLE) && rst_n;
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = ~cmd_op[2];
    assign capture   = (state == DRIVE) && (settle_cnt == 4'd0);
    assign rsp_hs    = (state == RESP) && rsp_ready;
    // AND/OR leave carry/overflow undriven on the ALU side
    assign logic_op  = alu_opp[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? DRIVE : RESP;
            DRIVE:   if (settle_cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LD;
        end else if (state == DRIVE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
            alu_cin <= 1'b0;
            alu_opp <= 3'd0;
        end else if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_cin <= cmd_cin;
            alu_opp <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= 4'd0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else if (accept && !legal) begin
            rsp_result   <= 4'd0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
        end else if (capture) begin
            rsp_result   <= alu_result;
            rsp_carry    <= logic_op ? 1'b0 : alu_carry;
            rsp_overflow <= logic_op ? 1'b0 : alu_overflow;
            rsp_err      <= 1'b0;
        end
    end

    // set has priority over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (capture && !logic_op && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      op_count <= '0;
        else if (rsp_hs) op_count <= op_count + 1'b1;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a 1-cycle-settle instance for the vector table,
// sticky and wrap checks, and a 3-cycle-settle instance for stall and reset-mid-op sequences.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU stub; logic ops and illegal ops drive junk 1s on carry/overflow
    function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = 5'd0; r = 4'hf; c = 1'b1; v = 1'b1;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b} - {4'd0, cin};
                r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = 4'hf;
        endcase
        return {v, c, r};
    endfunction

    // instance with SETTLE_CYCLES=1
    logic rst_n, cmd_valid, cmd_ready, cmd_cin, alu_cin, alu_carry, alu_overflow;
    logic rsp_valid, rsp_ready, rsp_carry, rsp_overflow, rsp_err, sticky_ovf, sticky_clr;
    logic [2:0] cmd_op, alu_opp;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [7:0] op_count;

    assign {alu_overflow, alu_carry, alu_result} = alu_model(alu_opp, alu_a, alu_b, alu_cin);

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opp(alu_opp),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr), .op_count(op_count)
    );

    // instance with SETTLE_CYCLES=3
    logic rst3_n, cmd_valid3, cmd_ready3, cmd_cin3, alu_cin3, alu_carry3, alu_overflow3;
    logic rsp_valid3, rsp_ready3, rsp_carry3, rsp_overflow3, rsp_err3, sticky_ovf3, sticky_clr3;
    logic [2:0] cmd_op3, alu_opp3;
    logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [7:0] op_count3;

    assign {alu_overflow3, alu_carry3, alu_result3} = alu_model(alu_opp3, alu_a3, alu_b3, alu_cin3);

    alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_cin(cmd_cin3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_opp(alu_opp3),
        .alu_result(alu_result3), .alu_carry(alu_carry3), .alu_overflow(alu_overflow3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_carry(rsp_carry3), .rsp_overflow(rsp_overflow3), .rsp_err(rsp_err3),
        .sticky_ovf(sticky_ovf3), .sticky_clr(sticky_clr3), .op_count(op_count3)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a, b;
        logic       cin;
        logic [3:0] res;
        logic       c, v, e;
    } vec_t;

    vec_t       vecs[10];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_sticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // one full transaction on the SETTLE_CYCLES=1 instance
    task automatic run_op(input vec_t v, input logic clr_at_capture);
        int lat;
        @(negedge clk);
        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_cin = v.cin;
        @(negedge clk);
        cmd_valid = 1'b0;
        sticky_clr = clr_at_capture;
        chk("alu_opp", alu_opp, v.op);
        chk("alu_a_b", {alu_a, alu_b}, {v.a, v.b});
        lat = 0;
        while (!rsp_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        sticky_clr = 1'b0;
        chk("latency", lat, v.e ? 0 : 1);
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_c_v_e", {rsp_carry, rsp_overflow, rsp_err}, {v.c, v.v, v.e});
        if (v.v) exp_sticky = 1'b1;
        chk("sticky_ovf", sticky_ovf, exp_sticky);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("op_count", op_count, exp_cnt);
        chk("rsp_valid_after", rsp_valid, 0);
    endtask

    initial begin
        int   lat;
        vec_t ill;
        vecs[0] = '{3'd0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3'd1, 4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd0, 4'hf, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3'd0, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'd1, 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{3'd1, 4'h0, 4'h1, 1'b0, 4'hf, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3'd2, 4'hc, 4'ha, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'd3, 4'ha, 4'h5, 1'b0, 4'hf, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'd6, 4'h9, 4'h9, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{3'd7, 4'h3, 4'hc, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_cin = 1'b0;
        rsp_ready = 1'b0; sticky_clr = 1'b0;
        rst3_n = 1'b0; cmd_valid3 = 1'b0; cmd_op3 = 3'd0; cmd_a3 = 4'd0; cmd_b3 = 4'd0;
        cmd_cin3 = 1'b0; rsp_ready3 = 1'b0; sticky_clr3 = 1'b0;

        #3;
        chk("reset_ready_valid", {cmd_ready, rsp_valid}, 0);
        chk("reset_alu", {alu_a, alu_b, alu_cin, alu_opp}, 0);
        chk("reset_rsp", {rsp_result, rsp_carry, rsp_overflow, rsp_err, sticky_ovf}, 0);
        chk("reset_count", op_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b0);

        // clear alone, then set and clear on the same edge, then clear alone
        @(negedge clk); sticky_clr = 1'b1;
        @(negedge clk); sticky_clr = 1'b0;
        chk("sticky_clr_alone", sticky_ovf, 0);
        exp_sticky = 1'b0;
        run_op(vecs[0], 1'b1);
        @(negedge clk); sticky_clr = 1'b1;
        @(negedge clk); sticky_clr = 1'b0;
        chk("sticky_clr_after_set", sticky_ovf, 0);
        exp_sticky = 1'b0;

        // 256 handshakes wrap the counter back to its starting value
        ill = vecs[8];
        lat = int'(exp_cnt);
        repeat (256) run_op(ill, 1'b0);
        chk("count_wrap", op_count, lat);

        // reset pulse mid-DRIVE on the 3-cycle instance
        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_op3 = 3'd0; cmd_a3 = 4'h5; cmd_b3 = 4'h2;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        chk("drive_state", {cmd_ready3, rsp_valid3}, 0);
        chk("drive_alu_a", alu_a3, 4'h5);
        #2 rst3_n = 1'b0;
        #1;
        chk("async_reset_alu", {alu_a3, alu_b3, alu_cin3, alu_opp3}, 0);
        chk("async_reset_rsp", {cmd_ready3, rsp_valid3, rsp_result3, rsp_err3, op_count3}, 0);
        @(negedge clk); rst3_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", cmd_ready3, 1);
        repeat (4) @(negedge clk);
        chk("no_rsp_after_midreset", {rsp_valid3, op_count3}, 0);

        // stall with rsp_ready low; new commands must be ignored
        cmd_valid3 = 1'b1; cmd_op3 = 3'd0; cmd_a3 = 4'h7; cmd_b3 = 4'h1; cmd_cin3 = 1'b0;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk("latency3", lat, 3);
        for (int i = 0; i < 5; i++) begin
            cmd_valid3 = 1'b1; cmd_op3 = 3'd2; cmd_a3 = 4'hf; cmd_b3 = 4'hf;
            @(negedge clk);
            chk("stall_hold", {rsp_valid3, rsp_result3, rsp_carry3, rsp_overflow3, rsp_err3},
                {1'b1, 4'h8, 1'b0, 1'b1, 1'b0});
            chk("stall_ready_count", {cmd_ready3, op_count3}, 0);
        end
        cmd_valid3 = 1'b0; rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;
        chk("stall_release_count", op_count3, 1);
        chk("stall_ignored_cmd", {rsp_valid3, alu_a3, alu_opp3}, {1'b0, 4'h7, 3'd0});
        chk("stall_sticky", sticky_ovf3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
